// File: rtl/command_encoder.sv
// command_encoder: turns load/set/enable/disable requests into UART byte
// sequences for the DDS command link. A load sends the 32-bit tuning word
// as four BYTEn/data pairs, least significant byte first. The other three
// requests each send a single command byte.
//
// Optional feature: define ENCODER_AUTO_SET_EN to append a SET byte to
// every load sequence, so the new tuning word takes effect at once.
//
// Command byte values come from the shared commands header macros. The
// fallback definitions below are used when that header is not in the build.

`ifndef BYTE0
`define BYTE0 8'h10
`endif
`ifndef BYTE1
`define BYTE1 8'h11
`endif
`ifndef BYTE2
`define BYTE2 8'h12
`endif
`ifndef BYTE3
`define BYTE3 8'h13
`endif
`ifndef ENABLE
`define ENABLE 8'h20
`endif
`ifndef DISABLE
`define DISABLE 8'h21
`endif
`ifndef SET
`define SET 8'h22
`endif

module command_encoder #(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m_in,
    input  logic        req_load,
    input  logic        req_set,
    input  logic        req_enable,
    input  logic        req_disable,
    input  logic        tx_busy,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        HOLD,
        WAIT,
        GAP
    } state_t;

    // Index of the final byte of a load sequence.
`ifdef ENCODER_AUTO_SET_EN
    localparam logic [3:0] LOAD_LAST = 4'd8;
`else
    localparam logic [3:0] LOAD_LAST = 4'd7;
`endif

    // Value the gap counter holds on the last GAP cycle.
    localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t      state;
    logic [31:0] word_q;     // tuning word latched on load acceptance
    logic [7:0]  cmd_q;      // command byte for single-byte sequences
    logic        is_load;    // sequence in flight is a load
    logic [3:0]  idx;        // index of the byte most recently sent
    logic [3:0]  last_idx;   // index of the final byte of this sequence
    logic [7:0]  gap_cnt;

    logic        any_req;
    logic [7:0]  req_cmd;
    logic [3:0]  next_idx;
    logic [7:0]  next_byte;
    logic        is_last;
    logic        advance;

    // Byte at position i of the sequence in flight.
    function automatic logic [7:0] byte_at(input logic [3:0]  i,
                                           input logic        ld,
                                           input logic [31:0] w,
                                           input logic [7:0]  c);
        if (!ld) return c;
        case (i)
            4'd0:    return `BYTE0;
            4'd1:    return w[7:0];
            4'd2:    return `BYTE1;
            4'd3:    return w[15:8];
            4'd4:    return `BYTE2;
            4'd5:    return w[23:16];
            4'd6:    return `BYTE3;
            4'd7:    return w[31:24];
            default: return `SET;
        endcase
    endfunction

    // Request decode, next-byte selection and the "byte finished" condition.
    // NOTE: every always_comb output gets a default first so that no path
    // leaves a value unassigned and infers a latch.
    always_comb begin
        any_req   = req_load | req_set | req_enable | req_disable;
        req_cmd   = `ENABLE;
        if (req_set)          req_cmd = `SET;
        else if (req_disable) req_cmd = `DISABLE;
        next_idx  = idx + 4'd1;
        next_byte = byte_at(next_idx, is_load, word_q, cmd_q);
        is_last   = (idx == last_idx);
        advance   = 1'b0;
        if (state == WAIT && !tx_busy && GAP_CYCLES == 0) advance = 1'b1;
        if (state == GAP && gap_cnt == GAP_LAST)          advance = 1'b1;
    end

    // Sequencer FSM with registered outputs.
    // NOTE: state and outputs use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            transmit <= 1'b0;
            tx_byte  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            word_q   <= 32'h0;
            cmd_q    <= 8'h00;
            is_load  <= 1'b0;
            idx      <= 4'd0;
            last_idx <= 4'd0;
            gap_cnt  <= 8'd0;
        end else begin
            transmit <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    // The done cycle is not an acceptance slot.
                    if (!busy && !done && any_req) begin
                        state    <= SEND;
                        busy     <= 1'b1;
                        transmit <= 1'b1;
                        idx      <= 4'd0;
                        is_load  <= req_load;
                        cmd_q    <= req_cmd;
                        if (req_load) word_q <= m_in;
                        last_idx <= req_load ? LOAD_LAST : 4'd0;
                        tx_byte  <= req_load ? `BYTE0 : req_cmd;
                    end
                end
                SEND: state <= HOLD;
                // tx_busy may not yet reflect the byte just strobed.
                HOLD: state <= WAIT;
                WAIT: begin
                    if (!tx_busy && GAP_CYCLES != 0) begin
                        gap_cnt <= 8'd0;
                        state   <= GAP;
                    end
                end
                GAP:     gap_cnt <= gap_cnt + 8'd1;
                default: state <= IDLE;
            endcase

            // A byte has fully finished: start the next one or close out.
            if (advance) begin
                if (is_last) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state    <= SEND;
                    transmit <= 1'b1;
                    idx      <= next_idx;
                    tx_byte  <= next_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_command_encoder.sv
// Self-checking bench for command_encoder. Two instances: one with
// GAP_CYCLES=0 (index 0) and one with GAP_CYCLES=3 (index 1), each driving
// a UART model that stays busy for 10 cycles per byte.
// Build with ENCODER_AUTO_SET_EN defined to check the appended SET byte.

module tb_command_encoder;

    localparam logic [7:0] C_BYTE0   = 8'h10;
    localparam logic [7:0] C_BYTE1   = 8'h11;
    localparam logic [7:0] C_BYTE2   = 8'h12;
    localparam logic [7:0] C_BYTE3   = 8'h13;
    localparam logic [7:0] C_ENABLE  = 8'h20;
    localparam logic [7:0] C_DISABLE = 8'h21;
    localparam logic [7:0] C_SET     = 8'h22;
`ifdef ENCODER_AUTO_SET_EN
    localparam int LOAD_N = 9;
`else
    localparam int LOAD_N = 8;
`endif
    localparam int LOG_N = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m_in;
    logic [1:0]  req_load, req_set, req_enable, req_disable;
    logic [1:0]  tx_busy, transmit, busy, done;
    logic [7:0]  tx_byte [2];

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    // Monitor / UART model state, written only by the monitor process.
    int         ucnt     [2];
    int         tx_cnt   [2];
    int         done_cnt [2];
    int         done_cyc [2];
    int         fall_cyc [2];
    logic       done_busy[2];
    logic [7:0] txlog    [2][LOG_N];
    int         tx_cyc   [2][LOG_N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    command_encoder #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .m_in(m_in),
        .req_load(req_load[0]), .req_set(req_set[0]),
        .req_enable(req_enable[0]), .req_disable(req_disable[0]),
        .tx_busy(tx_busy[0]), .transmit(transmit[0]), .tx_byte(tx_byte[0]),
        .busy(busy[0]), .done(done[0])
    );

    command_encoder #(.GAP_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .m_in(m_in),
        .req_load(req_load[1]), .req_set(req_set[1]),
        .req_enable(req_enable[1]), .req_disable(req_disable[1]),
        .tx_busy(tx_busy[1]), .transmit(transmit[1]), .tx_byte(tx_byte[1]),
        .busy(busy[1]), .done(done[1])
    );

    assign tx_busy[0] = (ucnt[0] != 0);
    assign tx_busy[1] = (ucnt[1] != 0);

    // UART model and output log, sampled on the falling edge.
    initial begin
        for (int i = 0; i < 2; i++) begin
            ucnt[i] = 0; tx_cnt[i] = 0; done_cnt[i] = 0;
            done_cyc[i] = 0; fall_cyc[i] = 0; done_busy[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    ucnt[i] = 0;
                end else begin
                    if (ucnt[i] != 0) begin
                        ucnt[i] = ucnt[i] - 1;
                        if (ucnt[i] == 0) fall_cyc[i] = cyc;
                    end
                    if (transmit[i]) begin
                        ucnt[i] = 10;
                        if (tx_cnt[i] < LOG_N) begin
                            txlog[i][tx_cnt[i]]  = tx_byte[i];
                            tx_cyc[i][tx_cnt[i]] = cyc;
                        end
                        tx_cnt[i] = tx_cnt[i] + 1;
                    end
                    if (done[i]) begin
                        done_cnt[i]  = done_cnt[i] + 1;
                        done_cyc[i]  = cyc;
                        done_busy[i] = busy[i];
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_min(input string name, input int act, input int min);
        checks++;
        if (act < min) begin
            errors++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
        end
    endtask

    // One-cycle request on instance i; rc is the cycle the request is high.
    task automatic pulse(input int i, input logic ld, input logic st, input logic en,
                         input logic ds, input logic [31:0] m, output int rc);
        @(negedge clk);
        m_in = m;
        req_load[i] = ld; req_set[i] = st; req_enable[i] = en; req_disable[i] = ds;
        rc = cyc;
        @(negedge clk);
        req_load[i] = 1'b0; req_set[i] = 1'b0; req_enable[i] = 1'b0; req_disable[i] = 1'b0;
    endtask

    // Wait (bounded) for done_cnt[i] to move past start, then check busy fell with it.
    task automatic wait_done(input int i, input int start, input string name);
        int k;
        for (k = 0; k < 3000 && done_cnt[i] == start; k++) @(posedge clk);
        check({name, "_done_seen"}, 32'(done_cnt[i] > start), 32'd1);
        check({name, "_busy_at_done"}, 32'(done_busy[i]), 32'd0);
    endtask

    typedef struct {
        logic        ld, st, en, ds;
        logic [31:0] m;
        int          n;
        logic [71:0] b;   // expected bytes, first byte in the top octet
    } vec_t;

    vec_t vt [8];

    initial begin
        int rc, s_tx, s_dn, dc, fall_en;
        logic [7:0] got;
        logic [7:0] exp_b;

        vt[0] = '{ld:1, st:0, en:0, ds:0, m:32'h12345678, n:LOAD_N,
                  b:{C_BYTE0, 8'h78, C_BYTE1, 8'h56, C_BYTE2, 8'h34, C_BYTE3, 8'h12, C_SET}};
        vt[1] = '{ld:0, st:1, en:0, ds:0, m:32'h0, n:1, b:{C_SET, 64'h0}};
        vt[2] = '{ld:0, st:0, en:1, ds:0, m:32'h0, n:1, b:{C_ENABLE, 64'h0}};
        vt[3] = '{ld:0, st:0, en:0, ds:1, m:32'h0, n:1, b:{C_DISABLE, 64'h0}};
        vt[4] = '{ld:1, st:0, en:1, ds:1, m:32'h12345678, n:LOAD_N,
                  b:{C_BYTE0, 8'h78, C_BYTE1, 8'h56, C_BYTE2, 8'h34, C_BYTE3, 8'h12, C_SET}};
        vt[5] = '{ld:0, st:1, en:1, ds:1, m:32'h0, n:1, b:{C_SET, 64'h0}};
        vt[6] = '{ld:0, st:0, en:1, ds:1, m:32'h0, n:1, b:{C_DISABLE, 64'h0}};
        vt[7] = '{ld:1, st:1, en:0, ds:0, m:32'hDEADBEEF, n:LOAD_N,
                  b:{C_BYTE0, 8'hEF, C_BYTE1, 8'hBE, C_BYTE2, 8'hAD, C_BYTE3, 8'hDE, C_SET}};

        rst_n = 1'b0; m_in = 32'h0;
        req_load = '0; req_set = '0; req_enable = '0; req_disable = '0;

        // Reset values on both instances.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_transmit%0d", i), 32'(transmit[i]), 32'd0);
            check($sformatf("rst_tx_byte%0d", i), 32'(tx_byte[i]), 32'h00);
            check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
            check($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
        end

        // First edge after reset release accepts a request (gap instance).
        @(negedge clk);
        rst_n = 1'b1; req_enable[1] = 1'b1;
        @(negedge clk);
        req_enable[1] = 1'b0;
        check("first_edge_transmit", 32'(transmit[1]), 32'd1);
        check("first_edge_byte", 32'(tx_byte[1]), 32'(C_ENABLE));
        check("first_edge_busy", 32'(busy[1]), 32'd1);
        wait_done(1, 0, "gap_enable");
        fall_en = fall_cyc[1];
        dc = done_cyc[1];
        // req_set in the cycle right after done.
        @(negedge clk);
        req_set[1] = 1'b1;
        @(negedge clk);
        req_set[1] = 1'b0;
        wait_done(1, 1, "gap_set");
        check("gap_byte_count", 32'(tx_cnt[1]), 32'd2);
        check("gap_second_byte", 32'(txlog[1][1]), 32'(C_SET));
        check_min("set_after_done", tx_cyc[1][1] - dc, 1);
        check_min("idle_gap_cycles", tx_cyc[1][1] - fall_en, 4);

        // Table of single-request and priority vectors on the no-gap instance.
        for (int v = 0; v < 8; v++) begin
            s_tx = tx_cnt[0];
            s_dn = done_cnt[0];
            pulse(0, vt[v].ld, vt[v].st, vt[v].en, vt[v].ds, vt[v].m, rc);
            check($sformatf("v%0d_busy_after_accept", v), 32'(busy[0]), 32'd1);
            wait_done(0, s_dn, $sformatf("v%0d", v));
            repeat (20) @(posedge clk);
            check($sformatf("v%0d_len", v), 32'(tx_cnt[0] - s_tx), 32'(vt[v].n));
            check($sformatf("v%0d_done_count", v), 32'(done_cnt[0] - s_dn), 32'd1);
            check($sformatf("v%0d_latency", v), 32'(tx_cyc[0][s_tx] - rc), 32'd1);
            for (int k = 0; k < vt[v].n; k++) begin
                exp_b = vt[v].b[71 - 8*k -: 8];
                got   = txlog[0][s_tx + k];
                check($sformatf("v%0d_byte%0d", v, k), 32'(got), 32'(exp_b));
            end
            exp_b = vt[v].b[71 - 8*(vt[v].n - 1) -: 8];
            check($sformatf("v%0d_tx_byte_hold", v), 32'(tx_byte[0]), 32'(exp_b));
        end

        // req_set while a load is in flight is dropped.
        s_tx = tx_cnt[0];
        s_dn = done_cnt[0];
        pulse(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678, rc);
        repeat (5) @(negedge clk);
        req_set[0] = 1'b1;
        @(negedge clk);
        req_set[0] = 1'b0;
        wait_done(0, s_dn, "busy_drop");
        repeat (30) @(posedge clk);
        check("busy_drop_len", 32'(tx_cnt[0] - s_tx), 32'(LOAD_N));
        check("busy_drop_byte7", 32'(txlog[0][s_tx + 7]), 32'h12);
        check("busy_drop_done_count", 32'(done_cnt[0] - s_dn), 32'd1);

        // m_in changed one cycle after acceptance does not reach the sequence.
        s_tx = tx_cnt[0];
        s_dn = done_cnt[0];
        pulse(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000000AA, rc);
        m_in = 32'hFFFFFFFF;
        wait_done(0, s_dn, "latch");
        check("latch_b1", 32'(txlog[0][s_tx + 1]), 32'hAA);
        check("latch_b3", 32'(txlog[0][s_tx + 3]), 32'h00);
        check("latch_b5", 32'(txlog[0][s_tx + 5]), 32'h00);
        check("latch_b7", 32'(txlog[0][s_tx + 7]), 32'h00);

        // Reset after the 3rd byte of a load aborts the sequence.
        repeat (5) @(posedge clk);
        s_tx = tx_cnt[0];
        s_dn = done_cnt[0];
        pulse(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678, rc);
        for (int k = 0; k < 500 && (tx_cnt[0] - s_tx) < 3; k++) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_transmit", 32'(transmit[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        check("abort_byte_count", 32'(tx_cnt[0] - s_tx), 32'd3);
        check("abort_no_done", 32'(done_cnt[0] - s_dn), 32'd0);
        s_tx = tx_cnt[0];
        pulse(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, rc);
        wait_done(0, s_dn, "after_abort");
        repeat (20) @(posedge clk);
        check("after_abort_len", 32'(tx_cnt[0] - s_tx), 32'd1);
        check("after_abort_byte", 32'(txlog[0][s_tx]), 32'(C_DISABLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/command_encoder.md
COMMAND_ENCODER -- requirements
Module: command_encoder

Interface
REQ-001 The block SHALL have one parameter: GAP_CYCLES, default 0, number of idle clock cycles inserted between consecutive transmitted bytes (0..255).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 m_in  input  32  DDS tuning word to be sent.
REQ-005 req_load  input  1  one-cycle request: send m_in as four BYTEn/data pairs.
REQ-006 req_set  input  1  one-cycle request: send the SET command.
REQ-007 req_enable  input  1  one-cycle request: send the ENABLE command.
REQ-008 req_disable  input  1  one-cycle request: send the DISABLE command.
REQ-009 tx_busy  input  1  UART transmitter busy; high while a byte is shifting out.
REQ-010 transmit  output  1  one-cycle strobe: tx_byte is valid, start UART transmission.
REQ-011 tx_byte  output  8  byte presented to the UART transmitter.
REQ-012 busy  output  1  high from request acceptance until sequence completion.
REQ-013 done  output  1  one-cycle pulse when the last byte of a sequence has finished.

Function
REQ-014 Command byte values SHALL come from the shared commands header macros BYTE0, BYTE1, BYTE2, BYTE3, ENABLE, DISABLE, SET.
REQ-015 Requests SHALL be sampled only in IDLE with busy low; requests arriving while busy SHALL be dropped, not queued.
REQ-016 Simultaneous requests SHALL be resolved by priority: load > set > disable > enable; lower-priority requests in the same cycle are dropped.
REQ-017 On acceptance of req_load, m_in SHALL be latched; later changes to m_in SHALL NOT affect the sequence in flight.
REQ-018 Load sequence SHALL be 8 bytes: BYTE0, m[7:0], BYTE1, m[15:8], BYTE2, m[23:16], BYTE3, m[31:24].
REQ-019 Set, enable and disable sequences SHALL each be the single corresponding command byte.
REQ-020 States: IDLE, SEND, HOLD, WAIT, GAP; IDLE->SEND on accepted request; SEND->HOLD; HOLD->WAIT; WAIT->GAP when tx_busy low and GAP_CYCLES>0, else WAIT->SEND (more bytes) or WAIT->IDLE (last byte).
REQ-021 GAP SHALL count GAP_CYCLES cycles, then go to SEND, or to IDLE if the last byte was sent.
REQ-022 transmit SHALL be high for exactly one cycle (SEND state), with tx_byte valid that cycle; first transmit occurs the cycle after acceptance.
REQ-023 tx_busy SHALL be ignored during HOLD (the cycle after transmit) to cover UART busy-assertion latency.
REQ-024 tx_byte SHALL hold its value until the next SEND.
REQ-025 busy SHALL rise the cycle after acceptance and fall in the same cycle done pulses.
REQ-026 done SHALL pulse for one cycle on the transition into IDLE at sequence end; a new request is accepted no earlier than the cycle after done.

Reset
REQ-027 While rst_n is low: state IDLE, transmit=0, tx_byte=8'h00, busy=0, done=0, latched word 0, byte index 0, gap counter 0.
REQ-028 Reset asserted mid-sequence SHALL abort it; after release, no remaining bytes are sent and no done pulse occurs.
REQ-029 The first request SHALL be accepted on the first rising clk edge with rst_n high.

Configuration
REQ-030 With ENCODER_AUTO_SET_EN defined, every load sequence SHALL append a SET byte as a 9th byte, and done pulses after it.
REQ-031 Without ENCODER_AUTO_SET_EN, load sequences SHALL be exactly 8 bytes and a SET command is sent only on req_set.

Verification
REQ-032 UART model busy 10 cycles/byte, GAP_CYCLES=0, req_load with m_in=32'h12345678 -> bytes BYTE0,78,BYTE1,56,BYTE2,34,BYTE3,12; 8 transmit pulses; one done.
REQ-033 Same load with ENCODER_AUTO_SET_EN defined -> 9 bytes ending in SET; done only after the 9th byte.
REQ-034 req_load and req_enable and req_disable in the same cycle -> only the load sequence is sent; req_set during busy -> no SET byte.
REQ-035 GAP_CYCLES=3, req_enable -> one ENABLE byte; req_set right after done -> SET transmit no earlier than the cycle after done; with 2 bytes, >=3 idle cycles between tx_busy fall and the next transmit.
REQ-036 rst_n pulsed low after the 3rd byte of a load -> transmit=0, busy=0 immediately; no further bytes or done; a following req_disable -> single DISABLE byte.
REQ-037 m_in changed to 32'hFFFFFFFF one cycle after req_load with m_in=32'h000000AA -> data bytes AA,00,00,00.
